// File: rtl/cpu_if_timeout_mon_if.sv
// rtl/cpu_if_timeout_mon_if.sv - CPU request/ack handshake bundle seen by the timeout monitor
interface cpu_if_timeout_mon_if;
  logic cpu_req;
  logic cpu_ack;
  logic cpu_if_timeout;
  logic cpu_busy;

  modport master (
    output cpu_req,
    output cpu_ack,
    input  cpu_if_timeout,
    input  cpu_busy
  );

  modport slave (
    input  cpu_req,
    input  cpu_ack,
    output cpu_if_timeout,
    output cpu_busy
  );
endinterface

// File: rtl/cpu_if_timeout_mon.sv
// rtl/cpu_if_timeout_mon.sv - CPU transaction watchdog with timeout pulse, sticky flag and event counter
module cpu_if_timeout_mon #(
  parameter int CNT_W = 16,
  parameter int EVT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_l,
  cpu_if_timeout_mon_if.slave  bus,
  input  logic [CNT_W-1:0]     timeout_limit,
  input  logic                 sticky_clr,
  output logic                 timeout_sticky,
  output logic [EVT_W-1:0]     timeout_evt_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tmo, tmo_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    tmo_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cpu_req && !bus.cpu_ack && (timeout_limit != '0)) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // Ack outranks a timeout landing on the same edge.
        if (bus.cpu_ack || !bus.cpu_req || (timeout_limit == '0)) begin
          state_nxt = ST_IDLE;
        end else if (cnt >= timeout_limit) begin
          state_nxt = ST_ABORT;
          tmo_nxt   = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      ST_ABORT: begin
        if (!bus.cpu_req) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= ST_IDLE;
      cnt   <= '0;
      tmo   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      tmo   <= tmo_nxt;
    end
  end

  // A clear coinciding with a timeout still records that timeout.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      timeout_sticky  <= 1'b0;
      timeout_evt_cnt <= '0;
    end else if (tmo_nxt) begin
      timeout_sticky <= 1'b1;
      if (sticky_clr) begin
        timeout_evt_cnt <= EVT_W'(1);
      end else if (timeout_evt_cnt != EVT_MAX) begin
        timeout_evt_cnt <= timeout_evt_cnt + EVT_W'(1);
      end
    end else if (sticky_clr) begin
      timeout_sticky  <= 1'b0;
      timeout_evt_cnt <= '0;
    end
  end

  assign bus.cpu_if_timeout = tmo;
  assign bus.cpu_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_cpu_if_timeout_mon.sv
// tb/tb_cpu_if_timeout_mon.sv - scoreboard bench for cpu_if_timeout_mon against a cycle-level watchdog model
module tb_cpu_if_timeout_mon;
  localparam int CNT_W = 16;
  localparam int EVT_W = 2;
  localparam int EVT_SAT = 3;

  typedef struct packed {
    logic             to;
    logic             busy;
    logic             stk;
    logic [EVT_W-1:0] evt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_l = 1'b0;
  logic [CNT_W-1:0] timeout_limit = '0;
  logic             sticky_clr = 1'b0;
  logic             timeout_sticky;
  logic [EVT_W-1:0] timeout_evt_cnt;

  cpu_if_timeout_mon_if bus ();

  cpu_if_timeout_mon #(.CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
    .clk             (clk),
    .reset_l         (reset_l),
    .bus             (bus.slave),
    .timeout_limit   (timeout_limit),
    .sticky_clr      (sticky_clr),
    .timeout_sticky  (timeout_sticky),
    .timeout_evt_cnt (timeout_evt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Reference: where the current transaction stands and how long it has waited.
  bit in_wait = 0;
  bit aborted = 0;
  int waited = 0;
  bit stk = 0;
  int evt_count = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic cycle(input bit req, input bit ack, input int lim, input bit clr, input bit rst);
    bit fire;
    exp_t e;
    @(negedge clk);
    bus.cpu_req   = req;
    bus.cpu_ack   = ack;
    timeout_limit = CNT_W'(lim);
    sticky_clr    = clr;
    reset_l       = rst;
    fire = 0;
    if (!rst) begin
      #1;
      check("async_rst_timeout", int'(bus.cpu_if_timeout), 0);
      check("async_rst_busy", int'(bus.cpu_busy), 0);
      check("async_rst_sticky", int'(timeout_sticky), 0);
      check("async_rst_evt", int'(timeout_evt_cnt), 0);
      in_wait = 0; aborted = 0; waited = 0; stk = 0; evt_count = 0;
    end else begin
      if (aborted) begin
        if (!req) aborted = 0;
      end else if (in_wait) begin
        if (ack || !req || lim == 0) begin
          in_wait = 0;
        end else if (waited >= lim) begin
          in_wait = 0; aborted = 1; fire = 1;
        end else begin
          waited++;
        end
      end else if (req && !ack && lim != 0) begin
        in_wait = 1; waited = 1;
      end
      if (clr) begin stk = 0; evt_count = 0; end
      if (fire) begin
        stk = 1;
        evt_count = (evt_count + 1 > EVT_SAT) ? EVT_SAT : evt_count + 1;
      end
    end
    e.to = fire; e.busy = in_wait | aborted; e.stk = stk; e.evt = EVT_W'(evt_count);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input int lim);
    for (int i = 0; i < n; i++) cycle(0, 0, lim, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cpu_if_timeout", int'(bus.cpu_if_timeout), int'(e.to));
        check("cpu_busy", int'(bus.cpu_busy), int'(e.busy));
        check("timeout_sticky", int'(timeout_sticky), int'(e.stk));
        check("timeout_evt_cnt", int'(timeout_evt_cnt), int'(e.evt));
      end
    end
  end

  initial begin : driver
    bit r, a, c, rs;
    int lim;
    bus.cpu_req = 0;
    bus.cpu_ack = 0;
    #1;
    check("reset_timeout", int'(bus.cpu_if_timeout), 0);
    check("reset_busy", int'(bus.cpu_busy), 0);
    check("reset_sticky", int'(timeout_sticky), 0);
    check("reset_evt", int'(timeout_evt_cnt), 0);
    idle(2, 4);

    // Normal ack at edge 3.
    for (int i = 0; i < 3; i++) cycle(1, 0, 4, 0, 1);
    cycle(1, 1, 4, 0, 1);
    idle(2, 4);
    // Timeout with no ack, held in ABORT a while.
    for (int i = 0; i < 9; i++) cycle(1, 0, 4, 0, 1);
    idle(2, 4);
    // Ack on the limit edge completes.
    for (int i = 0; i < 4; i++) cycle(1, 0, 4, 0, 1);
    cycle(1, 1, 4, 0, 1);
    idle(2, 4);
    // Late ack after timeout is ignored.
    for (int i = 0; i < 5; i++) cycle(1, 0, 4, 0, 1);
    cycle(1, 1, 4, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 4, 0, 1);
    idle(2, 4);
    // Watchdog disabled.
    for (int i = 0; i < 100; i++) cycle(1, 0, 0, 0, 1);
    idle(2, 0);
    // Live limit drop from 10 to 2 once the count is 6.
    for (int i = 0; i < 6; i++) cycle(1, 0, 10, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 2, 0, 1);
    idle(2, 2);
    // Saturation over five more timeouts.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 1);
      idle(1, 1);
    end
    // Clear on the timeout edge, then a bare clear.
    cycle(1, 0, 2, 0, 1);
    cycle(1, 0, 2, 0, 1);
    cycle(1, 0, 2, 1, 1);
    cycle(1, 0, 2, 0, 1);
    idle(2, 2);
    cycle(0, 0, 2, 1, 1);
    idle(2, 2);
    // Reset mid-WAIT at cnt=5, then a fresh request.
    for (int i = 0; i < 5; i++) cycle(1, 0, 20, 0, 1);
    cycle(1, 0, 20, 0, 0);
    cycle(0, 0, 20, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 2, 0, 1);
    idle(2, 2);

    r = 0; lim = 3;
    for (int i = 0; i < 2000; i++) begin
      if (!r) r = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 15) == 0) r = 0;
      a = r && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 31) == 0) lim = $urandom_range(0, 6);
      c = ($urandom_range(0, 40) == 0);
      rs = ($urandom_range(0, 300) != 0);
      cycle(r, a, lim, c, rs);
    end
    idle(2, lim);
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_if_timeout_mon.md
# cpu_if_timeout_mon

Watchdog stage that sits directly upstream of the CPU interface slave logic. It monitors each CPU request/acknowledge transaction and counts wait cycles against a programmable limit. When the slave fails to acknowledge in time, it produces the `cpu_if_timeout` pulse that the downstream slave and error logic consume. It also keeps a sticky timeout flag and a saturating event counter for software.

## Interface
Parameters:
- `CNT_W`, default 16: width of the wait counter and of `timeout_limit`.
- `EVT_W`, default 8: width of the saturating timeout event counter.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `reset_l`, input, 1: asynchronous, active-low reset.
- `cpu_req`, input, 1: master request; held high until the transaction ends.
- `cpu_ack`, input, 1: slave acknowledge, one-cycle pulse.
- `timeout_limit`, input, CNT_W: maximum wait cycles allowed; 0 disables the watchdog.
- `sticky_clr`, input, 1: clears `timeout_sticky` and `timeout_evt_cnt`.
- `cpu_if_timeout`, output, 1: registered one-cycle pulse on timeout.
- `cpu_busy`, output, 1: high while the FSM is not IDLE.
- `timeout_sticky`, output, 1: set by a timeout, cleared by `sticky_clr`.
- `timeout_evt_cnt`, output, EVT_W: number of timeouts, saturating.

## Operation
- FSM states: IDLE, WAIT, ABORT. The wait counter `cnt` is CNT_W wide and internal.
- IDLE:
  - If `cpu_req`=1 and `cpu_ack`=1: zero-wait transaction; stay in IDLE.
  - If `cpu_req`=1, `cpu_ack`=0 and `timeout_limit`≠0: go to WAIT with `cnt`<=1.
  - Otherwise stay in IDLE with `cnt`=0.
- WAIT, priority order:
  1. `cpu_ack`=1: go to IDLE, `cnt`<=0. Ack wins over a same-edge timeout.
  2. `cpu_req`=0: master abandoned the transaction; go to IDLE with no timeout.
  3. `timeout_limit`=0: watchdog disabled mid-transaction; go to IDLE with no timeout.
  4. `cnt` >= `timeout_limit`: `cpu_if_timeout`<=1 for one cycle; go to ABORT.
  5. Else: `cnt`<=`cnt`+1.
- `cnt` never wraps. Reaching the limit always ends WAIT before `cnt` could overflow.
- `timeout_limit` is compared live every cycle. Lowering it below `cnt` during WAIT fires the timeout on the next edge.
- ABORT:
  - Wait for `cpu_req`=0, then go to IDLE.
  - `cpu_ack` is ignored in ABORT; a late ack neither ends ABORT nor produces a pulse.
  - Holding `cpu_req` high keeps the FSM in ABORT indefinitely, with no second timeout.
- `cpu_busy` = (state≠IDLE), decoded directly from the state register.
- Sticky and event logic, on each edge where a timeout pulse is generated:
  - `timeout_sticky` is set.
  - `timeout_evt_cnt` increments, saturating at 2^EVT_W−1.
- Simultaneous `sticky_clr` and timeout: the clear is applied first, then the set. Result: `timeout_sticky`=1 and `timeout_evt_cnt`=1.
- `sticky_clr` alone: `timeout_sticky`<=0 and `timeout_evt_cnt`<=0 on the next edge.

## Timing
- Reset (`reset_l`=0, asynchronous): immediately state=IDLE, `cnt`=0, and all outputs are 0:
  - `cpu_if_timeout`=0
  - `cpu_busy`=0
  - `timeout_sticky`=0
  - `timeout_evt_cnt`=0
- Reset mid-transaction aborts with no pulse.
- Reset release is synchronous to `clk`. The first FSM transition happens on the first rising edge after `reset_l` goes high.
- Timeout latency: let edge 0 be the edge that samples `cpu_req`=1 in IDLE, with limit L.
  - If `cpu_ack` is not sampled at any edge 0..L, `cpu_if_timeout` goes high after edge L and stays high for exactly one cycle.
  - An ack sampled at edge L still completes normally.
- `cpu_busy` rises after edge 0 and falls after the edge that exits WAIT or ABORT.
- Back-to-back transactions: from IDLE, a new request can be accepted on the edge right after exit. The minimum gap is one cycle with `cpu_req`=0, because ABORT and abandon both require `req` low.

## Test plan
- Reset mid-WAIT:
  - Stimulus: `reset_l` pulsed low while in WAIT (`cnt`=5).
  - Response: all outputs 0 immediately; no pulse; next request starts with `cnt`=1.
- Normal ack:
  - Stimulus: L=4, `cpu_req` high, `cpu_ack` at edge 3.
  - Response: no timeout; `cpu_busy` high for 3 cycles; `timeout_evt_cnt`=0.
- Timeout:
  - Stimulus: L=4, no ack.
  - Response: `cpu_if_timeout` high for one cycle after edge 4; `timeout_sticky`=1; `timeout_evt_cnt`=1; FSM in ABORT until `cpu_req` drops.
- Boundary ack:
  - Stimulus: L=4, ack at edge 4.
  - Response: no timeout. Ack at edge 5 after a timeout is ignored; the FSM stays in ABORT.
- Disable and live limit change:
  - Stimulus: L=0 with `req` held 100 cycles.
  - Response: `cpu_busy`=0 and no timeout.
  - Stimulus: L=10, then changed to 2 when `cnt`=6.
  - Response: timeout fires on the next edge.
- Sticky, saturation and clear:
  - Stimulus: EVT_W=2, five timeouts.
  - Response: `timeout_evt_cnt`=3.
  - Stimulus: `sticky_clr` on the same edge as a timeout.
  - Response: `timeout_sticky`=1 and `timeout_evt_cnt`=1.
  - Stimulus: `sticky_clr` alone.
  - Response: both 0.
